// File: rtl/mccoy_pkg.sv
// Shared types and constants for the McCoy core and its program loader.
//   ldr_state_t      : loader FSM states
//   MCCOY_INSTR_W    : instruction word width
//   MCCOY_PC_W       : core program-counter width
//   MCCOY_FILL_INSTR : harmless word fed to the core outside the loaded program
package mccoy_pkg;

  localparam int unsigned MCCOY_INSTR_W = 6;
  localparam int unsigned MCCOY_PC_W    = 8;

  localparam logic [MCCOY_INSTR_W-1:0] MCCOY_FILL_INSTR = 6'h00;

  typedef enum logic [2:0] {
    LDR_IDLE   = 3'd0,
    LDR_LOAD   = 3'd1,
    LDR_LOADED = 3'd2,
    LDR_RUN    = 3'd3,
    LDR_DONE   = 3'd4
  } ldr_state_t;

endpackage

// File: rtl/mccoy_prog_ram.sv
// Program store: DEPTH x MCCOY_INSTR_W register array, synchronous write,
// asynchronous read. Contents are not reset.
//   clk       : write clock
//   we        : write enable
//   waddr     : write address
//   wdata     : write data
//   raddr     : read address
//   rd_data_c : read data (combinational from raddr)
module mccoy_prog_ram
  import mccoy_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [MCCOY_INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [MCCOY_INSTR_W-1:0] rd_data_c
);

  logic [MCCOY_INSTR_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port
  assign rd_data_c = mem[raddr];

endmodule

// File: rtl/mccoy_prog_loader.sv
// Program loader and instruction feeder for the McCoy core.
// A host streams instruction words in over valid/ready; after start the block
// serves mem[pc_in] to the core combinationally and flags done once the PC
// leaves the loaded program.
//   clk, reset  : clock, asynchronous active-high reset
//   load_valid  : host offers load_data
//   load_data   : instruction word
//   load_last   : load_data is the final program word
//   load_ready  : block accepts load_data this cycle (registered)
//   start       : pulse to enter RUN from IDLE or LOADED
//   pc_in       : core program counter
//   instr       : instruction to the core (combinational from pc_in)
//   prog_len    : number of loaded words (registered)
//   running     : high while in RUN (registered)
//   done        : sticky end-of-program flag (registered)
module mccoy_prog_loader
  import mccoy_pkg::*;
#(
  parameter int unsigned              DEPTH      = 16,
  parameter int unsigned              ADDR_W     = 4,
  parameter logic [MCCOY_INSTR_W-1:0] FILL_INSTR = MCCOY_FILL_INSTR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  input  logic [MCCOY_INSTR_W-1:0] load_data,
  output logic                     load_ready,
  input  logic                     load_last,
  input  logic                     start,
  input  logic [MCCOY_PC_W-1:0]    pc_in,
  output logic [MCCOY_INSTR_W-1:0] instr,
  output logic [ADDR_W:0]          prog_len,
  output logic                     running,
  output logic                     done
);

  localparam int unsigned     CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_PTR = CNT_W'(DEPTH - 1);

  ldr_state_t               state;
  logic [CNT_W-1:0]         wr_ptr;
  logic                     accept_c;
  logic                     in_range_c;
  logic [MCCOY_INSTR_W-1:0] rd_data_c;

  assign accept_c   = (state == LDR_LOAD) && load_valid && load_ready;
  // Full-width compare: PCs above DEPTH never alias back into the array
  assign in_range_c = pc_in < MCCOY_PC_W'(prog_len);
  assign instr      = ((state == LDR_RUN) && in_range_c) ? rd_data_c : FILL_INSTR;

  mccoy_prog_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .we        (accept_c),
    .waddr     (wr_ptr[ADDR_W-1:0]),
    .wdata     (load_data),
    .raddr     (pc_in[ADDR_W-1:0]),
    .rd_data_c (rd_data_c)
  );

  // Loader FSM with registered handshake and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LDR_IDLE;
      wr_ptr     <= '0;
      prog_len   <= '0;
      load_ready <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        LDR_IDLE: begin
          // start beats a same-cycle load_valid; the offered word is dropped
          if (start) begin
            state    <= LDR_RUN;
            prog_len <= '0;
            running  <= 1'b1;
          end else if (load_valid) begin
            // Word is not taken here; the host holds it until ready
            state      <= LDR_LOAD;
            load_ready <= 1'b1;
          end
        end
        LDR_LOAD: begin
          if (accept_c) begin
            wr_ptr <= wr_ptr + CNT_W'(1);
            if (load_last || (wr_ptr == LAST_PTR)) begin
              prog_len   <= wr_ptr + CNT_W'(1);
              state      <= LDR_LOADED;
              load_ready <= 1'b0;
            end
          end
        end
        LDR_LOADED: begin
          if (start) begin
            state   <= LDR_RUN;
            running <= 1'b1;
          end
        end
        LDR_RUN: begin
          if (!in_range_c) begin
            state   <= LDR_DONE;
            done    <= 1'b1;
            running <= 1'b0;
          end
        end
        LDR_DONE: begin
          state <= LDR_DONE;
        end
        default: begin
          state <= LDR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mccoy_prog_loader.sv
// Directed self-checking bench for mccoy_prog_loader.
module tb_mccoy_prog_loader;

  logic       clk;
  logic       reset;
  logic       load_valid;
  logic [5:0] load_data;
  logic       load_ready;
  logic       load_last;
  logic       start;
  logic [7:0] pc_in;
  logic [5:0] instr;
  logic [4:0] prog_len;
  logic       running;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

  mccoy_prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_last  (load_last),
    .start      (start),
    .pc_in      (pc_in),
    .instr      (instr),
    .prog_len   (prog_len),
    .running    (running),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 6'h00;
    start      = 1'b0;
    pc_in      = 8'h00;
    step();
    #2;
    reset = 1'b0;
    step();
  endtask

  // Offer one word after 'gap' idle cycles and hold it until accepted
  task automatic load_word(input logic [5:0] d, input logic l, input int gap);
    logic rdy;
    int   budget;
    load_valid = 1'b0;
    repeat (gap) step();
    load_valid = 1'b1;
    load_data  = d;
    load_last  = l;
    budget     = 0;
    do begin
      rdy = load_ready;
      step();
      budget++;
    end while (!rdy && budget < 20);
    n_assert++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_word_timeout: data %h never accepted", d);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    load_valid = 1'b1;
    load_data  = 6'h2A;
    step();
    n_assert++;
    if (load_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_ready: got %b expected 1", load_ready);
    end
    #3;
    reset = 1'b1;
    #1;
    n_assert++;
    if ({load_ready, running, done, prog_len, instr} !== {1'b0, 1'b0, 1'b0, 5'd0, 6'h00}) begin
      n_fail++;
      $display("FAIL reset_async: got rdy=%b run=%b done=%b len=%0d instr=%h expected 0 0 0 0 00",
               load_ready, running, done, prog_len, instr);
    end
    load_valid = 1'b0;
    reset      = 1'b0;
    step();
  endtask

  task automatic test_load_run();
    logic [5:0] words [5];
    words = '{6'h11, 6'h22, 6'h33, 6'h04, 6'h3F};
    do_reset();
    for (int i = 0; i < 5; i++) load_word(words[i], (i == 4), i % 2);
    n_assert++;
    if ({prog_len, load_ready, running, done} !== {5'd5, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL load5_status: got len=%0d rdy=%b run=%b done=%b expected 5 0 0 0",
               prog_len, load_ready, running, done);
    end
    // Words offered while LOADED must be ignored
    load_valid = 1'b1;
    load_data  = 6'h2A;
    repeat (3) step();
    load_valid = 1'b0;
    n_assert++;
    if ({prog_len, load_ready} !== {5'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL loaded_ignores_valid: got len=%0d rdy=%b expected 5 0", prog_len, load_ready);
    end
    pc_in = 8'd0;
    #1;
    n_assert++;
    if (instr !== 6'h00) begin
      n_fail++; $display("FAIL loaded_instr_fill: got %h expected 00", instr);
    end
    pulse_start();
    n_assert++;
    if (running !== 1'b1) begin
      n_fail++; $display("FAIL run_running: got %b expected 1", running);
    end
    for (int p = 0; p < 5; p++) begin
      pc_in = 8'(p);
      #1;
      n_assert++;
      if (instr !== words[p] || done !== 1'b0) begin
        n_fail++;
        $display("FAIL run_fetch pc=%0d: got instr=%h done=%b expected %h 0", p, instr, done, words[p]);
      end
      step();
    end
    pc_in = 8'd5;
    #1;
    n_assert++;
    if ({instr, done, running} !== {6'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL run_past_end: got instr=%h done=%b run=%b expected 00 0 1", instr, done, running);
    end
    step();
    n_assert++;
    if ({instr, done, running} !== {6'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL done_set: got instr=%h done=%b run=%b expected 00 1 0", instr, done, running);
    end
    pc_in = 8'd1;
    repeat (2) step();
    n_assert++;
    if ({instr, done, running} !== {6'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL done_sticky: got instr=%h done=%b run=%b expected 00 1 0", instr, done, running);
    end
  endtask

  task automatic test_full_depth();
    do_reset();
    for (int i = 0; i < 16; i++) load_word(6'(i * 3 + 1), 1'b0, 0);
    n_assert++;
    if ({load_ready, prog_len} !== {1'b0, 5'd16}) begin
      n_fail++;
      $display("FAIL full_after16: got rdy=%b len=%0d expected 0 16", load_ready, prog_len);
    end
    // 17th word must never be taken
    load_valid = 1'b1;
    load_data  = 6'h3E;
    repeat (3) step();
    load_valid = 1'b0;
    n_assert++;
    if ({load_ready, prog_len} !== {1'b0, 5'd16}) begin
      n_fail++;
      $display("FAIL full_word17: got rdy=%b len=%0d expected 0 16", load_ready, prog_len);
    end
    pulse_start();
    pc_in = 8'h00;
    #1;
    n_assert++;
    if (instr !== 6'h01) begin
      n_fail++; $display("FAIL full_pc0: got %h expected 01", instr);
    end
    pc_in = 8'h0F;
    #1;
    n_assert++;
    if (instr !== 6'h2E) begin
      n_fail++; $display("FAIL full_pc15: got %h expected 2e", instr);
    end
    pc_in = 8'h10;
    #1;
    n_assert++;
    if ({instr, running} !== {6'h00, 1'b1}) begin
      n_fail++; $display("FAIL full_no_alias: got instr=%h run=%b expected 00 1", instr, running);
    end
    step();
    n_assert++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL full_done: got %b expected 1", done);
    end
  endtask

  task automatic test_ignored_events();
    do_reset();
    load_word(6'h15, 1'b0, 0);
    pulse_start();
    n_assert++;
    if ({running, load_ready} !== {1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL start_in_load: got run=%b rdy=%b expected 0 1", running, load_ready);
    end
    load_word(6'h2B, 1'b1, 1);
    n_assert++;
    if (prog_len !== 5'd2) begin
      n_fail++; $display("FAIL ign_len: got %0d expected 2", prog_len);
    end
    pulse_start();
    pc_in      = 8'd0;
    load_valid = 1'b1;
    load_data  = 6'h3C;
    repeat (3) step();
    load_valid = 1'b0;
    n_assert++;
    if ({instr, running, load_ready} !== {6'h15, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL run_no_write: got instr=%h run=%b rdy=%b expected 15 1 0", instr, running, load_ready);
    end
    pc_in = 8'd1;
    #1;
    n_assert++;
    if (instr !== 6'h2B) begin
      n_fail++; $display("FAIL run_word1: got %h expected 2b", instr);
    end
  endtask

  task automatic test_empty_program();
    do_reset();
    start      = 1'b1;
    load_valid = 1'b1;
    load_data  = 6'h19;
    step();
    start      = 1'b0;
    load_valid = 1'b0;
    pc_in      = 8'd0;
    #1;
    n_assert++;
    if ({running, prog_len, load_ready, instr, done} !== {1'b1, 5'd0, 1'b0, 6'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL empty_run: got run=%b len=%0d rdy=%b instr=%h done=%b expected 1 0 0 00 0",
               running, prog_len, load_ready, instr, done);
    end
    step();
    n_assert++;
    if ({done, running} !== {1'b1, 1'b0}) begin
      n_fail++; $display("FAIL empty_done: got done=%b run=%b expected 1 0", done, running);
    end
  endtask

  task automatic test_reset_in_run();
    do_reset();
    load_word(6'h07, 1'b0, 0);
    load_word(6'h08, 1'b0, 0);
    load_word(6'h09, 1'b1, 0);
    pulse_start();
    pc_in = 8'd2;
    #1;
    n_assert++;
    if (instr !== 6'h09) begin
      n_fail++; $display("FAIL rr_fetch: got %h expected 09", instr);
    end
    step();
    #3;
    reset = 1'b1;
    #1;
    n_assert++;
    if ({running, prog_len, done, instr, load_ready} !== {1'b0, 5'd0, 1'b0, 6'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL rr_reset: got run=%b len=%0d done=%b instr=%h rdy=%b expected 0 0 0 00 0",
               running, prog_len, done, instr, load_ready);
    end
    reset = 1'b0;
    step();
    // Back in IDLE: a new word moves to LOAD and raises ready
    load_valid = 1'b1;
    load_data  = 6'h01;
    step();
    load_valid = 1'b0;
    n_assert++;
    if ({load_ready, running} !== {1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rr_idle: got rdy=%b run=%b expected 1 0", load_ready, running);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 6'h00;
    load_last  = 1'b0;
    start      = 1'b0;
    pc_in      = 8'h00;
    test_reset();
    test_load_run();
    test_full_depth();
    test_ignored_events();
    test_empty_program();
    test_reset_in_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
